// File: rtl/fetchunit_pkg.sv
// ---------------------------------------------------------------------------
// fetchunit_pkg: shared types for the instruction fetch stage.
//   addr_t / data_t     : 16-bit byte address, 8-bit data byte
//   ilen_t              : instruction length in bytes (1..3)
//   fetch_state_t       : fetch FSM states
//   RESET_VECTOR_DEFAULT: default fetch address after reset
// ---------------------------------------------------------------------------
package fetchunit_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;
  typedef logic [1:0]  ilen_t;

  typedef enum logic [1:0] {
    F_OP  = 2'd0,
    F_LO  = 2'd1,
    F_HI  = 2'd2,
    F_OUT = 2'd3
  } fetch_state_t;

  localparam addr_t RESET_VECTOR_DEFAULT = 16'h0000;

endpackage

// File: rtl/fetchunit_instrlen.sv
// ---------------------------------------------------------------------------
// fetchunit_instrlen: combinational opcode -> instruction length decoder.
// Opcode is viewed as aaa bbb cc.
//   opcode in : data_t  opcode byte
//   len    out: ilen_t  instruction length, 1..3
// ---------------------------------------------------------------------------
module fetchunit_instrlen
  import fetchunit_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  logic [2:0] bbb;
  logic [1:0] cc;

  assign bbb = opcode[4:2];
  assign cc  = opcode[1:0];

  always_comb begin
    len = 2'd1;
    case (cc)
      2'b01: begin
        // Group-one ALU ops: absolute-style modes carry a 16-bit operand.
        if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) len = 2'd3;
        else                                                   len = 2'd2;
      end
      2'b11: len = 2'd1; // illegal opcodes are treated as single-byte
      default: begin
        case (bbb)
          3'b000: begin
            // BRK/RTI/RTS are single-byte, JSR takes an absolute address.
            if (opcode == 8'h00 || opcode == 8'h40 || opcode == 8'h60) len = 2'd1;
            else if (opcode == 8'h20)                                   len = 2'd3;
            else                                                        len = 2'd2;
          end
          3'b001, 3'b100, 3'b101: len = 2'd2;
          3'b010, 3'b110:         len = 2'd1;
          default:                len = 2'd3; // 011, 111
        endcase
      end
    endcase
  end

endmodule

// File: rtl/fetchunit.sv
// ---------------------------------------------------------------------------
// fetchunit: instruction fetch stage. Reads opcode/operand bytes from a
// byte-wide program memory and hands one complete instruction to the CPU.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mem_rd/mem_addr (out)        memory read request / byte address
//   mem_ack/mem_rdata (in)       request accepted, read byte valid same cycle
//   redirect/redirect_pc (in)    flush and restart fetch at redirect_pc
//   ins_valid (out)/ins_ready(in) instruction bundle handshake
//   ins_opcode/op_lo/op_hi (out) opcode and operand bytes (0 if absent)
//   ins_len (out)                instruction length 1..3
//   ins_pc (out)                 address of the opcode byte
//   dbg_state (out)              current fetch FSM state (fetch_state_t)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high (mem_rd/mem_ack on the memory side, ins_valid/ins_ready on the
// CPU side). A requester holds its request and payload stable until the
// transfer, except that redirect or reset may abandon a memory request.
//
// Optional feature: define FETCHUNIT_TRACE_EN to print one line per accepted
// bundle and one line per redirect.
// ---------------------------------------------------------------------------
module fetchunit
  import fetchunit_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [7:0]  ins_opcode,
  output logic [7:0]  ins_op_lo,
  output logic [7:0]  ins_op_hi,
  output logic [1:0]  ins_len,
  output logic [15:0] ins_pc,
  output logic [1:0]  dbg_state
);

  fetch_state_t state_q, state_d;
  addr_t        fptr_q, fptr_d;
  data_t        opcode_q, opcode_d;
  data_t        op_lo_q, op_lo_d;
  data_t        op_hi_q, op_hi_d;
  ilen_t        len_q, len_d;
  addr_t        pc_q, pc_d;
  ilen_t        dec_len;

  fetchunit_instrlen u_instrlen (
    .opcode (mem_rdata),
    .len    (dec_len)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= F_OP;
      fptr_q   <= RESET_PC;
      opcode_q <= '0;
      op_lo_q  <= '0;
      op_hi_q  <= '0;
      len_q    <= 2'd1;
      pc_q     <= RESET_PC;
    end else begin
      state_q  <= state_d;
      fptr_q   <= fptr_d;
      opcode_q <= opcode_d;
      op_lo_q  <= op_lo_d;
      op_hi_q  <= op_hi_d;
      len_q    <= len_d;
      pc_q     <= pc_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    fptr_d   = fptr_q;
    opcode_d = opcode_q;
    op_lo_d  = op_lo_q;
    op_hi_d  = op_hi_q;
    len_d    = len_q;
    pc_d     = pc_q;
    if (redirect) begin
      // Any byte acked this cycle is dropped. A bundle accepted this cycle
      // has already been consumed by the CPU, so nothing is lost.
      state_d = F_OP;
      fptr_d  = redirect_pc;
    end else begin
      case (state_q)
        F_OP: if (mem_ack) begin
          opcode_d = mem_rdata;
          pc_d     = fptr_q;
          op_lo_d  = '0;
          op_hi_d  = '0;
          len_d    = dec_len;
          fptr_d   = fptr_q + 16'd1;
          state_d  = (dec_len == 2'd1) ? F_OUT : F_LO;
        end
        F_LO: if (mem_ack) begin
          op_lo_d = mem_rdata;
          fptr_d  = fptr_q + 16'd1;
          state_d = (len_q == 2'd2) ? F_OUT : F_HI;
        end
        F_HI: if (mem_ack) begin
          op_hi_d = mem_rdata;
          fptr_d  = fptr_q + 16'd1;
          state_d = F_OUT;
        end
        default: if (ins_ready) state_d = F_OP;
      endcase
    end
  end

  // Outputs
  always_comb begin
    mem_rd     = (state_q != F_OUT);
    mem_addr   = fptr_q;
    ins_valid  = (state_q == F_OUT);
    ins_opcode = opcode_q;
    ins_op_lo  = op_lo_q;
    ins_op_hi  = op_hi_q;
    ins_len    = len_q;
    ins_pc     = pc_q;
    dbg_state  = state_q;
  end

`ifdef FETCHUNIT_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ins_valid && ins_ready)
        $display("fetchunit: pc=%h op=%h lo=%h hi=%h len=%0d state=%s",
                 pc_q, opcode_q, op_lo_q, op_hi_q, len_q, state_q.name());
      if (redirect)
        $display("fetchunit: redirect fptr %h -> %h", fptr_q, redirect_pc);
    end
  end
`else
`endif

endmodule

// File: tb/tb_fetchunit.sv
// ---------------------------------------------------------------------------
// tb_fetchunit: self-checking bench for fetchunit. A memory model answers
// requests with configurable wait states; expected bundles are computed from
// memory contents and the length rules and queued; a monitor compares every
// presented bundle against the head of the queue.
// ---------------------------------------------------------------------------
module tb_fetchunit;

  logic        clk;
  logic        rst;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  ins_opcode;
  logic [7:0]  ins_op_lo;
  logic [7:0]  ins_op_hi;
  logic [1:0]  ins_len;
  logic [15:0] ins_pc;
  logic [1:0]  dbg_state;

  fetchunit dut (
    .clk         (clk),
    .rst         (rst),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins_opcode  (ins_opcode),
    .ins_op_lo   (ins_op_lo),
    .ins_op_hi   (ins_op_hi),
    .ins_len     (ins_len),
    .ins_pc      (ins_pc),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- state shared by bench processes ----------------
  logic [7:0]  mem [0:65535];
  logic [41:0] exp_q[$];      // {pc, opcode, op_lo, op_hi, len}
  int          checks = 0;
  int          passes = 0;
  bit          block_ready = 1'b0;
  bit          ready_rand  = 1'b0;
  bit          wait_rand   = 1'b0;
  int          wait_fixed  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_len(input logic [7:0] op);
    int grp;
    int mode;
    grp  = int'(op[1:0]);
    mode = int'(op[4:2]);
    if (grp == 3) return 2'd1;
    if (grp == 1) return (mode == 3 || mode >= 6) ? 2'd3 : 2'd2;
    if (mode == 0) begin
      if (op == 8'h20) return 2'd3;
      if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 2'd1;
      return 2'd2;
    end
    if (mode == 2 || mode == 6) return 2'd1;
    if (mode == 3 || mode == 7) return 2'd3;
    return 2'd2;
  endfunction

  // Push n expected bundles for straight-line execution from start.
  task automatic push_bundles(input logic [15:0] start, input int n);
    logic [15:0] pc;
    logic [7:0]  op, lo, hi;
    logic [1:0]  len;
    pc = start;
    for (int i = 0; i < n; i++) begin
      op  = mem[pc];
      len = ref_len(op);
      lo  = (len >= 2'd2) ? mem[pc + 16'd1] : 8'h00;
      hi  = (len == 2'd3) ? mem[pc + 16'd2] : 8'h00;
      exp_q.push_back({pc, op, lo, hi, len});
      pc  = pc + 16'(len);
    end
  endtask

  // ---------------- memory model ----------------
  initial begin
    logic [15:0] cur_addr;
    int          waited, target;
    bit          active, ack_prev;
    active = 0; ack_prev = 0; waited = 0; target = 0; cur_addr = '0;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst || !mem_rd) begin
        active  = 0;
        mem_ack = 1'b0;
      end else begin
        if (!active || ack_prev || mem_addr != cur_addr) begin
          active   = 1;
          cur_addr = mem_addr;
          waited   = 0;
          target   = wait_rand ? int'($urandom_range(0, 2)) : wait_fixed;
        end
        if (waited >= target) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 8'($urandom);
          waited++;
        end
        if (redirect) active = 0;
      end
      ack_prev = mem_ack;
    end
  end

  // ---------------- CPU ready driver ----------------
  // Only accept bundles the bench has predicted.
  initial begin
    ins_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ins_ready = !block_ready && (exp_q.size() > 0) &&
                  (ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && ins_valid) begin
        if (exp_q.size() > 0) begin
          check("bundle", {ins_pc, ins_opcode, ins_op_lo, ins_op_hi, ins_len}, exp_q[0]);
          check("mem_rd_while_valid", mem_rd, 1'b0);
          if (ins_ready) void'(exp_q.pop_front());
        end else if (ins_ready) begin
          checks++;
          $display("FAIL unexpected_bundle: got pc %h op %h, none expected", ins_pc, ins_opcode);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns in the first fetch cycle at pc.
  task automatic go_redirect(input logic [15:0] pc);
    @(posedge clk); #2;
    redirect = 1'b1; redirect_pc = pc;
    @(posedge clk); #2;
    redirect = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 40 * n + 20) begin
      @(posedge clk); #2;
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d bundles outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    @(negedge clk);
    while (!ins_valid && g < 100) begin @(negedge clk); g++; end
    if (!ins_valid) begin
      checks++;
      $display("FAIL valid_timeout: ins_valid 0 after 100 cycles, expected 1");
    end
  endtask

  // Counts cycles from the first request until ins_valid, checking mem_addr
  // advances one byte every per_byte cycles.
  task automatic measure(input string name, input logic [15:0] start,
                         input int per_byte, input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!ins_valid && n < 100) begin
      check({name, "_addr"}, mem_addr, start + 16'(n / per_byte));
      n++;
      @(negedge clk);
    end
    check({name, "_latency"}, n, exp_lat);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [15:0] pc;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'hA9; mem[16'h0001] = 8'h05; mem[16'h0002] = 8'hAA;
    mem[16'h0010] = 8'h8D; mem[16'h0011] = 8'h00; mem[16'h0012] = 8'h02;
    mem[16'h0100] = 8'hEA; mem[16'h0101] = 8'h20; mem[16'h0102] = 8'h34; mem[16'h0103] = 8'h12;
    mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h77;
    mem[16'h0300] = 8'hA2; mem[16'h0301] = 8'h10; mem[16'h0302] = 8'hE8;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", ins_valid, 1'b0);
    check("rst_len", ins_len, 2'd1);
    check("rst_pc", ins_pc, 16'h0000);
    check("rst_opcode", {ins_opcode, ins_op_lo, ins_op_hi}, 24'h0);
    check("rst_mem", {mem_rd, mem_addr}, {1'b1, 16'h0000});

    // Zero-wait: A9 05 then AA
    push_bundles(16'h0000, 2);
    @(posedge clk); #2; rst = 1'b0;
    measure("zw", 16'h0000, 1, 2);
    wait_drain(2);

    // Two wait states per byte: 8D 00 02
    wait_fixed = 2;
    go_redirect(16'h0010);
    push_bundles(16'h0010, 1);
    measure("ws2", 16'h0010, 3, 9);
    wait_drain(1);
    wait_fixed = 0;

    // CPU stall for 5 cycles, then resume at fptr
    block_ready = 1'b1;
    go_redirect(16'h0300);
    push_bundles(16'h0300, 2);
    wait_valid();
    repeat (5) @(negedge clk);
    block_ready = 1'b0;
    wait_drain(2);

    // Redirect during F_LO with an ack in the same cycle
    go_redirect(16'h0200);
    @(posedge clk); #2;
    redirect = 1'b1; redirect_pc = 16'h0100;
    @(posedge clk); #2;
    redirect = 1'b0;
    @(negedge clk);
    check("lo_redir_addr", {mem_rd, mem_addr}, {1'b1, 16'h0100});
    check("lo_redir_valid", ins_valid, 1'b0);
    push_bundles(16'h0100, 2);
    wait_drain(2);

    // Redirect in the same cycle as an accepted bundle
    block_ready = 1'b1;
    go_redirect(16'h0010);
    push_bundles(16'h0010, 1);
    wait_valid();
    @(posedge clk); #2; block_ready = 1'b0;
    @(posedge clk); #2; redirect = 1'b1; redirect_pc = 16'h0300;
    @(posedge clk); #2; redirect = 1'b0;
    check("redir_hs_consumed", exp_q.size(), 0);
    push_bundles(16'h0300, 2);
    wait_drain(2);

    // Operands straddling the address wrap
    mem[16'hFFFF] = 8'h4C; mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
    go_redirect(16'hFFFF);
    push_bundles(16'hFFFF, 1);
    wait_drain(1);
    @(negedge clk);
    check("wrap_fptr", mem_addr, 16'h0002);

    // Reset while in F_HI
    go_redirect(16'h0010);
    @(posedge clk); #2;
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    check("hi_rst_mem", {mem_rd, mem_addr}, {1'b1, 16'h0000});
    check("hi_rst_valid", ins_valid, 1'b0);
    check("hi_rst_len_pc", {ins_len, ins_pc}, {2'd1, 16'h0000});

    // Randomized program, waits and CPU backpressure
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    wait_rand  = 1'b1;
    ready_rand = 1'b1;
    for (int r = 0; r < 30; r++) begin
      pc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      n  = int'($urandom_range(1, 6));
      go_redirect(pc);
      push_bundles(pc, n);
      wait_drain(n);
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetchunit.md
Name: fetchunit

Overview:
- Instruction fetch stage directly upstream of the CPU decode/execute unit.
- Reads opcode and operand bytes from byte-wide program memory through a request/acknowledge handshake.
- Works out instruction length from the opcode and delivers one complete instruction (opcode, operands, length, address) to the CPU over a valid/ready handshake.
- The CPU redirects it on branch, jump, BRK or reset vector load.

Parameters:
- RESET_PC, 16'h0000, fetch address loaded on reset.

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- mem_rd  out  1  memory read request
- mem_addr  out  addr_t (16)  byte address of request
- mem_ack  in  1  request accepted; mem_rdata valid this cycle
- mem_rdata  in  data_t (8)  read byte
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  addr_t  new fetch address
- ins_valid  out  1  instruction bundle valid
- ins_ready  in  1  CPU accepts bundle
- ins_opcode  out  data_t  opcode byte
- ins_op_lo  out  data_t  operand byte 1 (0 if absent)
- ins_op_hi  out  data_t  operand byte 2 (0 if absent)
- ins_len  out  2  instruction length, 1..3
- ins_pc  out  addr_t  address of opcode byte

Behaviour:
- Reset (rst=1 at posedge):
  - state F_OP, fptr=RESET_PC.
  - ins_valid=0; ins_opcode/op_lo/op_hi=0; ins_len=1; ins_pc=RESET_PC.
  - rst mid-fetch abandons the request; an ack in the reset cycle is ignored.
- States: F_OP, F_LO, F_HI, F_OUT (enum fetch_state_t).
- Combinational memory outputs: mem_rd=1 in F_OP/F_LO/F_HI, else 0; mem_addr=fptr.
- mem_rd stays high and mem_addr stays stable until mem_ack, except on redirect/reset, where the request is abandoned. The memory model must tolerate this.
- F_OP, on mem_ack:
  - latch opcode, ins_pc=fptr, op_lo=op_hi=0, fptr+=1.
  - len=instrlen(mem_rdata).
  - len==1 -> F_OUT, else F_LO.
- F_LO, on ack: op_lo=rdata, fptr+=1; len==2 -> F_OUT, else F_HI.
- F_HI, on ack: op_hi=rdata, fptr+=1 -> F_OUT.
- F_OUT:
  - ins_valid=1.
  - ins_ready=1 -> ins_valid=0 next cycle, state F_OP.
  - Otherwise hold all outputs unchanged.
- Timing with zero-wait memory (ack same cycle as rd):
  - ins_valid rises N cycles after the opcode request cycle (N=len).
  - N+1 cycles per instruction when ins_ready is tied high.
  - Each wait cycle adds one.
- fptr wraps 16'hFFFF -> 16'h0000; operands may straddle the wrap.
- redirect has priority over everything except rst:
  - next state F_OP, fptr=redirect_pc, ins_valid=0.
  - mem_ack and mem_rdata in the same cycle are discarded.
  - redirect with ins_valid&ins_ready in the same cycle: the handshake completes (CPU consumed the bundle), then the redirect applies.
- Length rule (opcode = aaa bbb cc):
  - cc=01: bbb in {011,110,111} -> 3, else 2.
  - cc=00 or 10, bbb=000: 00/40/60 -> 1, 20 (JSR) -> 3, others -> 2.
  - cc=00 or 10, bbb in {001,100,101} -> 2.
  - cc=00 or 10, bbb in {010,110} -> 1.
  - cc=00 or 10, bbb in {011,111} -> 3.
  - cc=11 (illegal) -> 1.

Optional Feature:
- Macro: FETCHUNIT_TRACE_EN.
- Defined: one $display per accepted bundle (ins_valid&ins_ready) printing ins_pc, ins_opcode, op_lo, op_hi, ins_len, state.name(). Also one line per redirect with the old and new fptr.
- Undefined: no simulation output; RTL is functionally identical.

Decomposition:
- common_types (shared package):
  - addr_t and data_t (existing).
  - new fetch_state_t enum.
  - new ilen_t (2-bit).
  - constant RESET_VECTOR_DEFAULT.
- Sub-module instrlen: combinational opcode -> ilen_t. Reused later by disassembly/trace.

Test Plan:
- Memory A9 05 AA, zero-wait, ins_ready=1 -> bundle {pc 0, A9, 05, 00, len 2} at cycle 2, then {pc 2, AA, 00, 00, len 1}.
- Memory 8D 00 02 with 2 wait cycles per byte -> mem_addr 0,1,2 each held 3 cycles; bundle {8D, 00, 02, len 3} valid 9 cycles after first request.
- ins_ready=0 for 5 cycles after a bundle appears -> outputs stable, mem_rd=0; ready=1 -> next opcode fetched at fptr.
- redirect to 16'h0100 during F_LO with mem_ack=1 in the same cycle -> byte discarded, next mem_addr=0100, ins_valid=0.
- redirect_pc=16'hFFFF, memory 4C at FFFF, 34 at 0000, 12 at 0001 -> bundle {pc FFFF, 4C, 34, 12, len 3}, fptr ends 0002.
- rst asserted in F_HI -> next cycle mem_addr=RESET_PC, ins_valid=0, ins_len=1.
